// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled serial receive deframer.
// Recovers start / DATA_BITS data (LSB first) / stop frames from a raw,
// asynchronous rx line, stepping only on the baud oversample tick.
// Each frame ends in either a one-cycle valid pulse with the new word on
// data, or a one-cycle frame_err pulse when the stop bit is sampled low.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | line idle, waiting for a tick with rx_s low
//   S_START | counting to mid start bit; a high line there is a glitch
//   S_DATA  | sampling DATA_BITS data bits at each bit centre
//   S_STOP  | sampling the stop bit at its centre
//   S_BREAK | stop bit was low; wait for the line to return high
module uart_rx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                 CLKIN,
  input  logic                 RESETN,
  input  logic                 baud,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  // Tick count at mid start bit, and at each full bit period boundary.
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Two-flop synchronizer on the asynchronous line.
  logic rx_meta_q;
  logic rx_s_q;

  state_t               state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [IDX_W-1:0]     bit_idx_q,   bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [DATA_BITS-1:0] data_q,      data_d;
  logic                 valid_q,     valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q,      busy_d;

  // Shift register value after taking the current sample into the MSB;
  // after DATA_BITS samples the first bit received sits in bit 0.
  logic [DATA_BITS-1:0] shift_in;

  generate
    if (DATA_BITS == 1) begin : g_shift_one
      assign shift_in = rx_s_q;
    end else begin : g_shift_many
      assign shift_in = {rx_s_q, shift_q[DATA_BITS-1:1]};
    end
  endgenerate

  // Synchronize rx into the CLKIN domain; idles high out of reset.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Next-state logic: everything holds between ticks except the pulses,
  // which default low so they last exactly one CLKIN cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    if (baud) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end

        S_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_d = '0;
            if (rx_s_q) begin
              // Line went back high before mid start bit: noise, not a frame.
              state_d = S_IDLE;
            end else begin
              state_d   = S_DATA;
              bit_idx_d = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            shift_d   = shift_in;
            cnt_d     = '0;
            bit_idx_d = bit_idx_q + IDX_W'(1);
            if (bit_idx_q == IDX_LAST) begin
              state_d = S_STOP;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rx_s_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_BREAK;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_BREAK: begin
          // A held-low line must not look like a fresh start bit.
          if (rx_s_q) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // Deframer state and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: drives tick-aligned serial line patterns and checks
// the deframer every cycle against a line-scanning reference model.
module tb_uart_rx_frame;

  localparam int DB   = 8;
  localparam int OS   = 8;
  localparam int MAXT = 4096;

  logic          CLKIN = 1'b0;
  logic          RESETN;
  logic          baud;
  logic          rx;
  logic [DB-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          busy;

  uart_rx_frame #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .CLKIN    (CLKIN),
    .RESETN   (RESETN),
    .baud     (baud),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 CLKIN = ~CLKIN;

  int tests = 0;
  int fails = 0;

  // Line value per tick, and the number of CLKIN cycles that tick takes.
  bit   line [MAXT];
  int   gap  [MAXT];
  int   n;

  // Model predictions: state of the outputs right after tick k.
  bit         p_valid [MAXT];
  bit         p_ferr  [MAXT];
  bit         p_busy  [MAXT];
  logic [7:0] p_vbyte [MAXT];
  logic [7:0] p_data  [MAXT];
  logic [7:0] data_base;

  int tick_total = 0;
  int tick_base  = 0;
  bit ticked     = 1'b0;
  bit chk_en     = 1'b0;
  int vld_seen, fe_seen, busy_ticks, first_vld_tick;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add_bits(input bit v, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      line[n] = v;
      gap[n]  = 4;
      n++;
    end
  endtask

  task automatic add_frame(input logic [7:0] b, input bit stp, input int stop_len);
    add_bits(1'b0, OS);
    for (int j = 0; j < DB; j++) add_bits(b[j], OS);
    add_bits(stp, stop_len);
  endtask

  // Scan the whole tick sequence: a low tick starts a frame, its sample
  // points are at +OS/2 (start), +OS/2+OS*(j+1) (data j), +OS/2+OS*(DB+1)
  // (stop); a low stop bit keeps the receiver busy until the first high tick.
  task automatic predict();
    int i, dec, stp, j;
    logic [7:0] b, cur;
    for (int k = 0; k < n; k++) begin
      p_valid[k] = 1'b0;
      p_ferr[k]  = 1'b0;
      p_busy[k]  = 1'b0;
      p_vbyte[k] = 8'h00;
    end
    i = 0;
    while (i < n) begin
      if (line[i]) begin
        i++;
        continue;
      end
      dec = i + OS / 2;
      if (dec >= n) begin
        for (int k = i; k < n; k++) p_busy[k] = 1'b1;
        i = n;
        continue;
      end
      if (line[dec]) begin
        for (int k = i; k < dec; k++) p_busy[k] = 1'b1;
        i = dec + 1;
        continue;
      end
      stp = dec + OS * (DB + 1);
      if (stp >= n) begin
        for (int k = i; k < n; k++) p_busy[k] = 1'b1;
        i = n;
        continue;
      end
      b = 8'h00;
      for (int q = 0; q < DB; q++) b[q] = line[dec + OS * (q + 1)];
      for (int k = i; k < stp; k++) p_busy[k] = 1'b1;
      if (line[stp]) begin
        p_valid[stp] = 1'b1;
        p_vbyte[stp] = b;
        i = stp + 1;
      end else begin
        p_ferr[stp] = 1'b1;
        j = stp;
        while (j < n && !line[j]) begin
          p_busy[j] = 1'b1;
          j++;
        end
        i = j + 1;
      end
    end
    cur = data_base;
    for (int k = 0; k < n; k++) begin
      if (p_valid[k]) cur = p_vbyte[k];
      p_data[k] = cur;
    end
  endtask

  task automatic start_scn();
    tick_base      = tick_total;
    vld_seen       = 0;
    fe_seen        = 0;
    busy_ticks     = 0;
    first_vld_tick = -1;
    predict();
    chk_en = 1'b1;
  endtask

  task automatic play(input int upto);
    for (int k = 0; k < upto; k++) begin
      rx   = line[k];
      baud = 1'b0;
      repeat (gap[k] - 1) @(negedge CLKIN);
      baud = 1'b1;
      @(negedge CLKIN);
      baud = 1'b0;
    end
  endtask

  function automatic int count_valid();
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(p_valid[k]);
    return c;
  endfunction

  function automatic int count_ferr();
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(p_ferr[k]);
    return c;
  endfunction

  function automatic int count_busy();
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(p_busy[k]);
    return c;
  endfunction

  task automatic build_random();
    int r;
    n = 0;
    add_bits(1'b1, 2);
    repeat (6) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        add_frame(8'($urandom), 1'b1, $urandom_range(5, 8));
      end else if (r < 7) begin
        add_frame(8'($urandom), 1'b0, OS);
        add_bits(1'b0, $urandom_range(0, 20));
        add_bits(1'b1, $urandom_range(1, 4));
      end else if (r < 9) begin
        add_bits(1'b0, $urandom_range(1, 3));
        add_bits(1'b1, $urandom_range(2, 5));
      end else begin
        add_bits(1'b1, $urandom_range(0, 10));
      end
    end
    add_bits(1'b1, 90);
    for (int k = 0; k < n; k++) gap[k] = $urandom_range(3, 6);
  endtask

  // Count ticks the DUT actually sees.
  always @(posedge CLKIN) begin
    ticked = RESETN && baud;
    if (ticked) tick_total++;
  end

  int         ck;
  logic       ev, ef, eb;
  logic [7:0] ed;

  // Per-cycle comparison of every output against the model.
  always @(negedge CLKIN) begin
    #2;
    if (chk_en && RESETN) begin
      ck = tick_total - tick_base;
      ev = 1'b0;
      ef = 1'b0;
      eb = 1'b0;
      ed = data_base;
      if (ck > 0) begin
        ev = ticked && p_valid[ck-1];
        ef = ticked && p_ferr[ck-1];
        eb = p_busy[ck-1];
        ed = p_data[ck-1];
      end
      check("valid", 32'(valid), 32'(ev));
      check("frame_err", 32'(frame_err), 32'(ef));
      check("busy", 32'(busy), 32'(eb));
      check("data", 32'(data), 32'(ed));
      if (valid) begin
        vld_seen++;
        if (first_vld_tick < 0) first_vld_tick = ck - 1;
      end
      if (frame_err) fe_seen++;
      if (ticked && busy) busy_ticks++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int vld_before;
    RESETN = 1'b0;
    baud   = 1'b0;
    rx     = 1'b1;
    repeat (3) @(negedge CLKIN);
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    RESETN = 1'b1;
    repeat (2) @(negedge CLKIN);

    // Single 0x55 frame, baud every 4 clocks.
    n = 0;
    add_bits(1'b1, 2);
    add_frame(8'h55, 1'b1, OS);
    add_bits(1'b1, 6);
    data_base = 8'h00;
    start_scn();
    check("model_valid_tick", 32'(p_valid[78]), 32'h1);
    check("model_byte_55", 32'(p_vbyte[78]), 32'h55);
    play(n);
    check("f55_valid_count", vld_seen, 1);
    check("f55_ferr_count", fe_seen, 0);
    check("f55_data", 32'(data), 32'h55);
    check("f55_busy_after", 32'(busy), 32'h0);
    check("f55_valid_tick", first_vld_tick, 78);
    data_base = p_data[n-1];

    // Back-to-back 0xA3, 0x0F.
    n = 0;
    add_bits(1'b1, 2);
    add_frame(8'hA3, 1'b1, OS);
    add_frame(8'h0F, 1'b1, OS);
    add_bits(1'b1, 6);
    start_scn();
    check("model_byte_a3", 32'(p_vbyte[78]), 32'hA3);
    play(n);
    check("b2b_valid_count", vld_seen, 2);
    check("b2b_ferr_count", fe_seen, 0);
    check("b2b_data", 32'(data), 32'h0F);
    data_base = p_data[n-1];

    // Start glitch: two low ticks.
    n = 0;
    add_bits(1'b1, 2);
    add_bits(1'b0, 2);
    add_bits(1'b1, 10);
    start_scn();
    check("model_glitch_busy", count_busy(), 4);
    play(n);
    check("glitch_valid_count", vld_seen, 0);
    check("glitch_ferr_count", fe_seen, 0);
    check("glitch_busy_ticks", busy_ticks, 4);
    check("glitch_data", 32'(data), 32'h0F);
    data_base = p_data[n-1];

    // Framing error on 0x3C, 40-tick break, then 0x81.
    n = 0;
    add_bits(1'b1, 2);
    add_frame(8'h3C, 1'b0, OS);
    add_bits(1'b0, 40);
    add_bits(1'b1, 3);
    add_frame(8'h81, 1'b1, OS);
    add_bits(1'b1, 6);
    start_scn();
    check("model_ferr_count", count_ferr(), 1);
    play(n);
    check("ferr_pulse_count", fe_seen, 1);
    check("ferr_valid_count", vld_seen, 1);
    check("ferr_then_81", 32'(data), 32'h81);
    data_base = p_data[n-1];

    // Reset during data bit 4 of 0xFF, then 0x12.
    n = 0;
    add_bits(1'b1, 2);
    add_frame(8'hFF, 1'b1, OS);
    start_scn();
    play(45);
    vld_before = vld_seen;
    chk_en = 1'b0;
    check("pre_reset_busy", 32'(busy), 32'h1);
    RESETN = 1'b0;
    #1;
    check("midrst_data", 32'(data), 32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_frame_err", 32'(frame_err), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("aborted_no_valid", vld_before, 0);
    rx = 1'b1;
    repeat (3) @(negedge CLKIN);
    RESETN = 1'b1;
    repeat (2) @(negedge CLKIN);
    n = 0;
    add_bits(1'b1, 2);
    add_frame(8'h12, 1'b1, OS);
    add_bits(1'b1, 6);
    data_base = 8'h00;
    start_scn();
    play(n);
    check("after_rst_valid_count", vld_seen, 1);
    check("after_rst_data", 32'(data), 32'h12);
    data_base = p_data[n-1];

    // Baud held low for 100 clocks mid-frame.
    n = 0;
    add_bits(1'b1, 2);
    add_frame(8'h5A, 1'b1, OS);
    add_bits(1'b1, 6);
    gap[40] = 100;
    start_scn();
    play(n);
    check("gated_valid_count", vld_seen, 1);
    check("gated_data", 32'(data), 32'h5A);
    data_base = p_data[n-1];

    // Randomized line patterns with jittered tick spacing.
    for (int s = 0; s < 8; s++) begin
      build_random();
      start_scn();
      play(n);
      check("rand_valid_count", vld_seen, count_valid());
      check("rand_ferr_count", fe_seen, count_ferr());
      data_base = p_data[n-1];
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
